// File: rtl/bram_pkg.sv
// Shared constants and helpers for the bank-swapped true dual-port RAM.
// Latency: none; constants and a pure combinational function.
// Backpressure: none.
package bram_pkg;

  // Read-during-write behaviour of a port's registered output
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Wrapper sequencer states
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  // Invert the mask bits only when swap is on and every qualifier bit is set
  function automatic logic [31:0] remap_addr(
    input logic [31:0] addr,
    input logic        swap,
    input logic [31:0] mask,
    input logic [31:0] qual
  );
    if (swap && ((addr & qual) == qual)) begin
      return addr ^ mask;
    end
    return addr;
  endfunction

endpackage

// File: rtl/bram_tdp_swap_if.sv
// Bus bundle for both RAM ports plus swap/clear/collision control.
// Latency: wiring only.
// Backpressure: none; busy tells the master that accesses are being ignored.
interface bram_tdp_swap_if #(
  parameter int DATA = 8,
  parameter int ADDR = 10
);
  logic            a_en;
  logic            a_wr;
  logic [ADDR-1:0] a_addr;
  logic [DATA-1:0] a_din;
  logic [DATA-1:0] a_dout;
  logic            b_en;
  logic            b_wr;
  logic [ADDR-1:0] b_addr;
  logic [DATA-1:0] b_din;
  logic [DATA-1:0] b_dout;
  logic            swap_wr;
  logic            swap_din;
  logic            swap;
  logic            busy;
  logic            collision;
  logic            coll_clr;

  modport slave (
    input  a_en, a_wr, a_addr, a_din, b_en, b_wr, b_addr, b_din,
    input  swap_wr, swap_din, coll_clr,
    output a_dout, b_dout, swap, busy, collision
  );

  modport master (
    output a_en, a_wr, a_addr, a_din, b_en, b_wr, b_addr, b_din,
    output swap_wr, swap_din, coll_clr,
    input  a_dout, b_dout, swap, busy, collision
  );
endinterface

// File: rtl/bram_tdp_core.sv
// Storage array with two independent registered read/write ports.
// Latency: 1 cycle read; dout holds when the port is idle.
// Backpressure: none; same-address write/write lets port B win.
module bram_tdp_core
  import bram_pkg::*;
#(
  parameter int DATA   = 8,
  parameter int ADDR   = 10,
  parameter int A_MODE = RDW_READ_FIRST,
  parameter int B_MODE = RDW_READ_FIRST
) (
  input  logic            clk,
  input  logic            dout_clr,
  input  logic            a_en,
  input  logic            a_wr,
  input  logic [ADDR-1:0] a_addr,
  input  logic [DATA-1:0] a_din,
  output logic [DATA-1:0] a_dout,
  input  logic            b_en,
  input  logic            b_wr,
  input  logic [ADDR-1:0] b_addr,
  input  logic [DATA-1:0] b_din,
  output logic [DATA-1:0] b_dout
);
  localparam int DEPTH = 1 << ADDR;

  logic [DATA-1:0] mem_q [DEPTH];
  logic [DATA-1:0] a_dout_q, a_dout_d;
  logic [DATA-1:0] b_dout_q, b_dout_d;

  // Array writes; B is applied last so it owns a same-address write/write
  always_ff @(posedge clk) begin
    if (a_en && a_wr) mem_q[a_addr] <= a_din;
    if (b_en && b_wr) mem_q[b_addr] <= b_din;
  end

  // Next output data: cleared, held, own write data (write-first) or array contents
  always_comb begin
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    if (dout_clr) begin
      a_dout_d = '0;
      b_dout_d = '0;
    end else begin
      if (a_en) a_dout_d = (a_wr && A_MODE == RDW_WRITE_FIRST) ? a_din : mem_q[a_addr];
      if (b_en) b_dout_d = (b_wr && B_MODE == RDW_WRITE_FIRST) ? b_din : mem_q[b_addr];
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    a_dout_q <= a_dout_d;
    b_dout_q <= b_dout_d;
  end

  assign a_dout = a_dout_q;
  assign b_dout = b_dout_q;
endmodule

// File: rtl/bram_tdp_swap.sv
// Dual-port RAM wrapper: post-reset fill, address bank swap, sticky collision flag.
// Latency: 1 cycle read; fill takes 2**ADDR cycles after reset releases.
// Backpressure: none; all port and swap writes are dropped while busy.
module bram_tdp_swap
  import bram_pkg::*;
#(
  parameter int              DATA      = 8,
  parameter int              ADDR      = 10,
  parameter logic [ADDR-1:0] SWAP_MASK = 'h100,
  parameter logic [ADDR-1:0] SWAP_QUAL = 'h200,
  parameter logic [DATA-1:0] INIT_VAL  = 'hE9,
  parameter int              A_MODE    = RDW_READ_FIRST,
  parameter int              B_MODE    = RDW_READ_FIRST
) (
  input  logic               clk,
  input  logic               reset,
  bram_tdp_swap_if.slave     bus
);
  logic [0:0]      state_q, state_d;
  logic [ADDR-1:0] clr_addr_q, clr_addr_d;
  logic            swap_q, swap_d;
  logic            coll_q, coll_d;

  logic            run;
  logic            coll_set;
  logic [ADDR-1:0] eff_a, eff_b;
  logic            core_a_en, core_a_wr, core_b_en;
  logic [ADDR-1:0] core_a_addr;
  logic [DATA-1:0] core_a_din;

  assign run   = (state_q == ST_RUN);
  assign eff_a = ADDR'(remap_addr(32'(bus.a_addr), swap_q, 32'(SWAP_MASK), 32'(SWAP_QUAL)));
  assign eff_b = ADDR'(remap_addr(32'(bus.b_addr), swap_q, 32'(SWAP_MASK), 32'(SWAP_QUAL)));

  // Fill sequencer: walk every address once, then hand the array to the ports
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + ADDR'(1);
      if (clr_addr_q == {ADDR{1'b1}}) state_d = ST_RUN;
    end
  end

  // Swap register and sticky collision; a new collision beats coll_clr
  always_comb begin
    swap_d   = (run && bus.swap_wr) ? bus.swap_din : swap_q;
    coll_set = run && bus.a_en && bus.b_en && (eff_a == eff_b) && (bus.a_wr || bus.b_wr);
    coll_d   = coll_set | (coll_q & ~bus.coll_clr);
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      swap_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      swap_q     <= swap_d;
      coll_q     <= coll_d;
    end
  end

  // Port A is borrowed by the fill sequencer until the array is initialised
  always_comb begin
    core_a_en   = reset && (run ? bus.a_en : 1'b1);
    core_a_wr   = run ? bus.a_wr : 1'b1;
    core_a_addr = run ? eff_a : clr_addr_q;
    core_a_din  = run ? bus.a_din : INIT_VAL;
    core_b_en   = reset && run && bus.b_en;
  end

  bram_tdp_core #(
    .DATA   (DATA),
    .ADDR   (ADDR),
    .A_MODE (A_MODE),
    .B_MODE (B_MODE)
  ) u_core (
    .clk      (clk),
    .dout_clr (!reset || !run),
    .a_en     (core_a_en),
    .a_wr     (core_a_wr),
    .a_addr   (core_a_addr),
    .a_din    (core_a_din),
    .a_dout   (bus.a_dout),
    .b_en     (core_b_en),
    .b_wr     (bus.b_wr),
    .b_addr   (eff_b),
    .b_din    (bus.b_din),
    .b_dout   (bus.b_dout)
  );

  assign bus.busy      = (state_q == ST_CLEAR);
  assign bus.swap      = swap_q;
  assign bus.collision = coll_q;
endmodule

// File: tb/tb_bram_tdp_swap.sv
// Directed bench for bram_tdp_swap with a dout scoreboard per port.
// Latency: expects read data one cycle after each enabled access.
// Backpressure: none; accesses are only issued after the fill completes.
module tb_bram_tdp_swap;
  localparam int DATA = 8;
  localparam int ADDR = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bram_tdp_swap_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

  bram_tdp_swap #(
    .DATA(DATA), .ADDR(ADDR),
    .SWAP_MASK(10'h100), .SWAP_QUAL(10'h200), .INIT_VAL(8'hE9),
    .A_MODE(0), .B_MODE(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] v;
    int         id;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_vec = 0;
  int   n_err = 0;
  int   vid   = 0;
  bit   run_phase = 1'b0;
  bit   a_fire = 1'b0;
  bit   b_fire = 1'b0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Record which ports were accessed at each edge once the array is live
  always @(posedge clk) begin
    a_fire <= run_phase && bus.a_en;
    b_fire <= run_phase && bus.b_en;
  end

  // Scoreboard: pop the expected dout for every access that just completed
  always @(negedge clk) begin
    if (a_fire) begin
      if (qa.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL a_dout unexpected: got %h expected none", bus.a_dout);
      end else begin
        ea = qa.pop_front();
        chk("a_dout", ea.id, 32'(bus.a_dout), 32'(ea.v));
      end
    end
    if (b_fire) begin
      if (qb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_dout unexpected: got %h expected none", bus.b_dout);
      end else begin
        eb = qb.pop_front();
        chk("b_dout", eb.id, 32'(bus.b_dout), 32'(eb.v));
      end
    end
  end

  task automatic idle();
    bus.a_en = 0; bus.a_wr = 0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_en = 0; bus.b_wr = 0; bus.b_addr = '0; bus.b_din = '0;
    bus.swap_wr = 0; bus.swap_din = 0; bus.coll_clr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access cycle on both ports plus control; expected douts queued at issue
  task automatic acc(
    input logic ae, input logic aw, input logic [9:0] aa, input logic [7:0] ad, input logic [7:0] xa,
    input logic be, input logic bw, input logic [9:0] ba, input logic [7:0] bd, input logic [7:0] xb,
    input logic sw, input logic sd, input logic cc
  );
    bus.a_en = ae; bus.a_wr = aw; bus.a_addr = aa; bus.a_din = ad;
    bus.b_en = be; bus.b_wr = bw; bus.b_addr = ba; bus.b_din = bd;
    bus.swap_wr = sw; bus.swap_din = sd; bus.coll_clr = cc;
    vid++;
    if (ae) qa.push_back('{v: xa, id: vid});
    if (be) qb.push_back('{v: xb, id: vid});
    step();
    idle();
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    #300000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    idle();
    reset = 1'b0;
    repeat (3) step();
    chk("rst_busy", 0, 32'(bus.busy), 1);
    chk("rst_a_dout", 0, 32'(bus.a_dout), 0);
    chk("rst_b_dout", 0, 32'(bus.b_dout), 0);
    chk("rst_swap", 0, 32'(bus.swap), 0);
    chk("rst_collision", 0, 32'(bus.collision), 0);

    // Start a fill, try to disturb it, then restart it partway through
    reset = 1'b1;
    repeat (100) step();
    bus.a_en = 1; bus.a_wr = 1; bus.a_addr = 10'h007; bus.a_din = 8'h77;
    bus.b_en = 1; bus.b_wr = 1; bus.b_addr = 10'h008; bus.b_din = 8'h88;
    bus.swap_wr = 1; bus.swap_din = 1;
    step();
    idle();
    chk("clr_swap_ignored", 0, 32'(bus.swap), 0);
    chk("clr_a_dout_zero", 0, 32'(bus.a_dout), 0);
    chk("clr_b_dout_zero", 0, 32'(bus.b_dout), 0);
    repeat (399) step();
    chk("clr_busy_mid", 0, 32'(bus.busy), 1);
    reset = 1'b0;
    step();
    chk("rerst_busy", 0, 32'(bus.busy), 1);
    reset = 1'b1;
    cnt = 0;
    while (bus.busy && cnt < 2000) begin
      cnt++;
      step();
    end
    chk("clr_busy_cycles", 0, 32'(cnt), 1024);
    run_phase = 1'b1;

    // Fill contents, including the address written during the fill
    acc(1,0,'h007,0,'hE9, 1,0,'h3FF,0,'hE9, 0,0,0);
    acc(1,0,'h000,0,'hE9, 1,0,'h200,0,'hE9, 0,0,0);

    // Swap remap
    acc(1,1,'h205,'h11,'hE9, 0,0,0,0,0, 0,0,0);
    acc(1,0,'h205,0,'h11, 0,0,0,0,0, 0,0,0);
    acc(0,0,0,0,0, 0,0,0,0,0, 1,1,0);
    chk("swap_set", 0, 32'(bus.swap), 1);
    acc(1,0,'h305,0,'h11, 1,0,'h105,0,'hE9, 0,0,0);
    acc(1,0,'h105,0,'hE9, 1,0,'h205,0,'hE9, 0,0,0);

    // Read-during-write: A read-first, B write-first
    acc(1,1,'h005,'h3C,'hE9, 1,1,'h006,'h3C,'h3C, 0,0,0);
    chk("no_coll_diff_addr", vid, 32'(bus.collision), 0);
    acc(1,0,'h005,0,'h3C, 1,0,'h006,0,'h3C, 0,0,0);

    // Write/write collision, B wins; sticky until cleared
    acc(1,1,'h010,'hAA,'hE9, 1,1,'h010,'h55,'h55, 0,0,0);
    chk("ww_coll_set", vid, 32'(bus.collision), 1);
    acc(1,0,'h010,0,'h55, 0,0,0,0,0, 0,0,0);
    chk("coll_sticky", vid, 32'(bus.collision), 1);
    acc(0,0,0,0,0, 0,0,0,0,0, 0,0,1);
    chk("coll_cleared", vid, 32'(bus.collision), 0);

    // Read/write collisions; reader sees old data; set beats clear
    acc(1,0,'h020,0,'hE9, 1,1,'h020,'h66,'h66, 0,0,0);
    chk("rw_coll_set", vid, 32'(bus.collision), 1);
    acc(1,1,'h020,'h77,'h66, 1,0,'h020,0,'h66, 0,0,1);
    chk("coll_set_wins", vid, 32'(bus.collision), 1);
    acc(0,0,0,0,0, 0,0,0,0,0, 0,0,1);
    chk("coll_cleared2", vid, 32'(bus.collision), 0);
    acc(1,0,'h020,0,'h77, 1,0,'h021,0,'hE9, 0,0,0);
    chk("no_coll_reads", vid, 32'(bus.collision), 0);

    // Swapped write lands at 'h205; different raw addresses do not collide
    acc(1,1,'h305,'h99,'h11, 1,0,'h205,0,'hE9, 0,0,0);
    chk("no_coll_swapped", vid, 32'(bus.collision), 0);

    // swap_wr takes effect only for the following access
    acc(1,0,'h205,0,'hE9, 0,0,0,0,0, 1,0,0);
    chk("swap_clear", vid, 32'(bus.swap), 0);
    acc(1,0,'h205,0,'h99, 0,0,0,0,0, 0,0,0);
    acc(1,0,'h205,0,'h99, 0,0,0,0,0, 1,1,0);
    acc(1,0,'h205,0,'hE9, 1,0,'h305,0,'h99, 0,0,0);

    // Outputs hold while idle
    acc(0,0,0,0,0, 0,0,0,0,0, 0,0,0);
    chk("a_dout_hold", vid, 32'(bus.a_dout), 'hE9);
    chk("b_dout_hold", vid, 32'(bus.b_dout), 'h99);

    repeat (3) step();
    chk("qa_drained", 0, 32'(qa.size()), 0);
    chk("qb_drained", 0, 32'(qb.size()), 0);
    summary();
    $finish;
  end
endmodule
